// File: rtl/adder_stim_pkg.sv
// Shared types and constants for the adder stimulus generator / result checker.
// The LFSR step helper is used by the checker to advance its operand source.
package adder_stim_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        DRAIN = 2'b10,
        DONE  = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        MODE_LFSR  = 2'b00,
        MODE_COUNT = 2'b01,
        MODE_ONES  = 2'b10,
        MODE_RSVD  = 2'b11
    } mode_t;

    localparam int LFSR_W = 32;
    localparam logic [LFSR_W-1:0] LFSR_POLY = 32'h8020_0003;

    // One Galois step: shift right, fold the polynomial in when a one drops out.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        logic [LFSR_W-1:0] r;
        r = s >> 1;
        if (s[0]) begin
            r = r ^ LFSR_POLY;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO holding expected results; occupancy-counted, with a
// synchronous clear used for start and timeout flushes.
module sync_fifo #(
    parameter int G_WIDTH = 9,
    parameter int G_DEPTH = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_clr_i,
    input  logic               i_push_i,
    input  logic               i_pop_i,
    input  logic [G_WIDTH-1:0] i_data_i,
    output logic [G_WIDTH-1:0] o_data_o,
    output logic               o_full_o,
    output logic               o_empty_o
);

    localparam int AW = $clog2(G_DEPTH);

    logic [G_WIDTH-1:0] mem_q [G_DEPTH];
    logic [AW-1:0]      wr_ptr_q;
    logic [AW-1:0]      rd_ptr_q;
    logic [AW:0]        count_q;
    logic               wr_en;
    logic               rd_en;

    // A push while full is only accepted when a pop frees the slot this cycle.
    assign rd_en = i_pop_i && !o_empty_o;
    assign wr_en = i_push_i && (!o_full_o || rd_en);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (i_clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= i_data_i;
        end
    end

    assign o_data_o  = mem_q[rd_ptr_q];
    assign o_full_o  = (count_q == (AW+1)'(G_DEPTH));
    assign o_empty_o = (count_q == '0);

endmodule

// File: rtl/adder_stim_checker.sv
// Drives operand pairs into an adder, keeps expected sums in a FIFO and checks
// each returned result against the FIFO head, reporting counts and flags.
module adder_stim_checker
    import adder_stim_pkg::*;
#(
    parameter int          G_DATA_WIDTH      = 8,
    parameter int          G_MAX_OUTSTANDING = 4,
    parameter int          G_TIMEOUT         = 16,
    parameter logic [31:0] G_SEED            = 32'hACE1_0001
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic [1:0]              i_mode,
    input  logic [15:0]             i_num_txn,
    output logic                    o_valid,
    output logic [G_DATA_WIDTH-1:0] o_A,
    output logic [G_DATA_WIDTH-1:0] o_B,
    input  logic                    i_valid,
    input  logic [G_DATA_WIDTH:0]   i_C,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_pass,
    output logic                    o_timeout,
    output logic                    o_spurious,
    output logic [15:0]             o_err_count,
    output logic [15:0]             o_txn_count
);

    localparam int W  = G_DATA_WIDTH;
    localparam int TW = $clog2(G_TIMEOUT + 1);

    state_t              state_q, state_d;
    mode_t               mode_q;
    logic [15:0]         num_txn_q;
    logic [15:0]         issued_q;
    logic [LFSR_W-1:0]   lfsr_q;
    logic                valid_q;
    logic [W-1:0]        a_q, b_q;
    logic                timeout_q;
    logic                spurious_q;
    logic [15:0]         err_q;
    logic [15:0]         txn_q;
    logic [TW-1:0]       tmo_q, tmo_d;

    logic                start_ok;
    logic                busy;
    logic                issue;
    logic                tmo_hit;
    logic                pop;
    logic                spur;
    logic                mismatch;
    logic                fifo_full, fifo_empty, fifo_clr;
    logic [W:0]          fifo_head;
    logic [W-1:0]        op_a, op_b;
    logic [W:0]          exp_sum;

    assign start_ok = i_start && (state_q == IDLE || state_q == DONE);
    assign busy     = (state_q == RUN) || (state_q == DRAIN);

    // Timeout fires on the cycle the no-response count would reach G_TIMEOUT.
    assign tmo_hit  = busy && !fifo_empty && !i_valid &&
                      (tmo_q == TW'(G_TIMEOUT - 1));

    assign issue    = (state_q == RUN) && (issued_q != num_txn_q) &&
                      !fifo_full && !tmo_hit;

    // A start wipes all bookkeeping, so a result landing that cycle is dropped.
    assign pop      = i_valid && !fifo_empty && !start_ok;
    assign spur     = i_valid && fifo_empty && !start_ok;
    assign mismatch = pop && (fifo_head != i_C);
    assign fifo_clr = start_ok || tmo_hit;

    always_comb begin
        op_a = '0;
        op_b = '0;
        case (mode_q)
            MODE_COUNT: begin
                op_a = issued_q[W-1:0];
                op_b = ~issued_q[W-1:0];
            end
            MODE_ONES: begin
                op_a = '1;
                op_b = '1;
            end
            default: begin
                op_a = lfsr_q[W-1:0];
                op_b = lfsr_q[2*W-1:W];
            end
        endcase
    end

    assign exp_sum = {1'b0, op_a} + {1'b0, op_b};

    always_comb begin
        tmo_d = '0;
        if (busy && !fifo_empty && !i_valid) begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_ok) begin
                    state_d = (i_num_txn == 16'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (tmo_hit) begin
                    state_d = DONE;
                end else if (issued_q == num_txn_q) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (tmo_hit || fifo_empty) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            mode_q     <= MODE_LFSR;
            num_txn_q  <= '0;
            issued_q   <= '0;
            lfsr_q     <= G_SEED;
            valid_q    <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            timeout_q  <= 1'b0;
            spurious_q <= 1'b0;
            err_q      <= '0;
            txn_q      <= '0;
            tmo_q      <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= issue;
            if (start_ok) begin
                mode_q     <= mode_t'(i_mode);
                num_txn_q  <= i_num_txn;
                issued_q   <= '0;
                lfsr_q     <= G_SEED;
                timeout_q  <= 1'b0;
                spurious_q <= 1'b0;
                err_q      <= '0;
                txn_q      <= '0;
                tmo_q      <= '0;
            end else begin
                if (issue) begin
                    issued_q <= issued_q + 16'd1;
                    a_q      <= op_a;
                    b_q      <= op_b;
                    lfsr_q   <= lfsr_step(lfsr_q);
                end
                if (tmo_hit) begin
                    timeout_q <= 1'b1;
                end
                if (spur) begin
                    spurious_q <= 1'b1;
                end
                if ((mismatch || spur) && err_q != 16'hFFFF) begin
                    err_q <= err_q + 16'd1;
                end
                if (pop) begin
                    txn_q <= txn_q + 16'd1;
                end
                tmo_q <= tmo_d;
            end
        end
    end

    sync_fifo #(
        .G_WIDTH (W + 1),
        .G_DEPTH (G_MAX_OUTSTANDING)
    ) u_exp_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clr_i   (fifo_clr),
        .i_push_i  (issue),
        .i_pop_i   (pop),
        .i_data_i  (exp_sum),
        .o_data_o  (fifo_head),
        .o_full_o  (fifo_full),
        .o_empty_o (fifo_empty)
    );

    assign o_valid     = valid_q;
    assign o_A         = a_q;
    assign o_B         = b_q;
    assign o_busy      = busy;
    assign o_done      = (state_q == DONE);
    assign o_pass      = o_done && (err_q == 16'd0) && !timeout_q && !spurious_q;
    assign o_timeout   = timeout_q;
    assign o_spurious  = spurious_q;
    assign o_err_count = err_q;
    assign o_txn_count = txn_q;

endmodule

// File: tb/tb_adder_stim_checker.sv
// Bench: the checker drives a 1-cycle behavioural adder; vector table plus
// directed sequences for spurious results, timeout and mid-run reset.
module tb_adder_stim_checker;

    localparam logic [31:0] SEED = 32'hACE1_0001;
    localparam logic [31:0] POLY = 32'h8020_0003;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [15:0] num_txn = 16'd0;
    logic        o_valid;
    logic [7:0]  o_A, o_B;
    logic        dut_ivalid;
    logic [8:0]  adder_c;
    logic        adder_vld;
    logic        o_busy, o_done, o_pass, o_timeout, o_spurious;
    logic [15:0] o_err_count, o_txn_count;

    logic        resp_en  = 1'b1;
    logic        force_vld = 1'b0;
    int          flip_at  = 0;
    int          resp_cnt;

    int          n_total  = 0;
    int          n_passed = 0;

    always #5 clk = ~clk;

    assign dut_ivalid = (adder_vld && resp_en) || force_vld;

    adder_stim_checker #(
        .G_DATA_WIDTH      (8),
        .G_MAX_OUTSTANDING (4),
        .G_TIMEOUT         (16),
        .G_SEED            (SEED)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_mode      (mode),
        .i_num_txn   (num_txn),
        .o_valid     (o_valid),
        .o_A         (o_A),
        .o_B         (o_B),
        .i_valid     (dut_ivalid),
        .i_C         (adder_c),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_pass      (o_pass),
        .o_timeout   (o_timeout),
        .o_spurious  (o_spurious),
        .o_err_count (o_err_count),
        .o_txn_count (o_txn_count)
    );

    // Behavioural adder with one cycle of latency; optionally corrupts one result.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            adder_vld <= 1'b0;
            adder_c   <= '0;
            resp_cnt  <= 0;
        end else begin
            adder_vld <= o_valid;
            adder_c   <= ({1'b0, o_A} + {1'b0, o_B}) ^
                         {8'd0, (o_valid && resp_cnt == flip_at - 1)};
            if (start) begin
                resp_cnt <= 0;
            end else if (o_valid) begin
                resp_cnt <= resp_cnt + 1;
            end
        end
    end

    function automatic logic [31:0] model_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_passed++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_start(input logic [1:0] m, input int n);
        mode    = m;
        num_txn = 16'(n);
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    typedef struct {
        logic [1:0] mode;
        int         num;
        int         flip;
        int         exp_txn;
        int         exp_err;
        int         exp_pass;
    } vec_t;

    vec_t vecs [4];

    task automatic run_vec(input vec_t v, input int idx);
        logic [31:0] m;
        int pulses;
        int bad;
        int cyc;
        m = SEED;
        pulses = 0;
        bad = 0;
        cyc = 0;
        flip_at = v.flip;
        do_start(v.mode, v.num);
        while (!o_done && cyc < v.num + 8) begin
            if (o_valid) begin
                case (v.mode)
                    2'b01: if (o_A != 8'(pulses) || o_B != ~8'(pulses)) bad++;
                    2'b10: if (o_A != 8'hFF || o_B != 8'hFF) bad++;
                    default: begin
                        if (o_A != m[7:0] || o_B != m[15:8]) bad++;
                        m = model_step(m);
                    end
                endcase
                pulses++;
            end
            tick();
            cyc++;
        end
        chk($sformatf("v%0d done", idx), int'(o_done), 1);
        chk($sformatf("v%0d pass", idx), int'(o_pass), v.exp_pass);
        chk($sformatf("v%0d txn_count", idx), int'(o_txn_count), v.exp_txn);
        chk($sformatf("v%0d err_count", idx), int'(o_err_count), v.exp_err);
        chk($sformatf("v%0d pulses", idx), pulses, v.num);
        chk($sformatf("v%0d operand errors", idx), bad, 0);
        chk($sformatf("v%0d timeout", idx), int'(o_timeout), 0);
        flip_at = 0;
    endtask

    initial begin
        int pulses;
        int cyc;
        int last_pulse;

        vecs[0] = '{mode: 2'b10, num: 3,   flip: 0, exp_txn: 3,   exp_err: 0, exp_pass: 1};
        vecs[1] = '{mode: 2'b01, num: 256, flip: 0, exp_txn: 256, exp_err: 0, exp_pass: 1};
        vecs[2] = '{mode: 2'b00, num: 100, flip: 5, exp_txn: 100, exp_err: 1, exp_pass: 0};
        vecs[3] = '{mode: 2'b11, num: 6,   flip: 0, exp_txn: 6,   exp_err: 0, exp_pass: 1};

        #12;
        chk("reset o_valid", int'(o_valid), 0);
        chk("reset o_A", int'(o_A), 0);
        chk("reset o_B", int'(o_B), 0);
        chk("reset busy", int'(o_busy), 0);
        chk("reset done", int'(o_done), 0);
        chk("reset pass", int'(o_pass), 0);
        chk("reset flags", int'({o_timeout, o_spurious}), 0);
        chk("reset counts", int'({o_err_count, o_txn_count}), 0);
        rst = 1'b0;
        tick();

        // Result with nothing outstanding while idle.
        force_vld = 1'b1;
        tick();
        force_vld = 1'b0;
        chk("spurious flag", int'(o_spurious), 1);
        chk("spurious err_count", int'(o_err_count), 1);
        chk("spurious txn_count", int'(o_txn_count), 0);
        do_start(2'b00, 0);
        chk("zero-txn done", int'(o_done), 1);
        chk("zero-txn pass", int'(o_pass), 1);
        chk("start clears spurious", int'(o_spurious), 0);
        chk("start clears err_count", int'(o_err_count), 0);

        for (int i = 0; i < 4; i++) begin
            run_vec(vecs[i], i);
        end

        // No responses: the FIFO fills after 4 issues, then the timeout fires.
        resp_en = 1'b0;
        pulses = 0;
        cyc = 0;
        last_pulse = 0;
        do_start(2'b01, 10);
        while (!o_done && cyc < 60) begin
            if (o_valid) begin
                pulses++;
                last_pulse = cyc;
            end
            tick();
            cyc++;
        end
        chk("timeout pulses", pulses, 4);
        chk("timeout flag", int'(o_timeout), 1);
        chk("timeout done", int'(o_done), 1);
        chk("timeout pass", int'(o_pass), 0);
        chk("timeout busy", int'(o_busy), 0);
        chk("timeout txn_count", int'(o_txn_count), 0);
        chk("timeout latency window", int'((cyc - last_pulse) >= 10 && (cyc - last_pulse) <= 16), 1);
        repeat (3) tick();
        chk("no issue after timeout", int'(o_valid), 0);
        resp_en = 1'b1;

        // Asynchronous reset mid-run, just after the fifth pulse appears.
        pulses = 0;
        cyc = 0;
        do_start(2'b01, 20);
        while (pulses < 5 && cyc < 40) begin
            if (o_valid) pulses++;
            if (pulses < 5) begin
                tick();
                cyc++;
            end
        end
        chk("pre-reset pulses", pulses, 5);
        chk("pre-reset o_valid", int'(o_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async reset o_valid", int'(o_valid), 0);
        chk("async reset txn_count", int'(o_txn_count), 0);
        chk("async reset err_count", int'(o_err_count), 0);
        chk("async reset busy", int'(o_busy), 0);
        tick();
        rst = 1'b0;
        tick();
        do_start(2'b00, 0);
        chk("post-reset done", int'(o_done), 1);
        chk("post-reset pass", int'(o_pass), 1);

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
